// File: rtl/add_test_pkg.sv
// Shared definitions for the adder test-harness run sequencer: state encoding
// and the default geometry of the harness pipeline.
package add_test_pkg;

  localparam int ADDR_WIDTH_DEF  = 11;
  localparam int LATENCY_DEF     = 6;   // RAM read + operand mux/delay + adder + result delay
  localparam int LOCK_CYCLES_DEF = 16;
  localparam int CNT_WIDTH_DEF   = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RUN       = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

endpackage

// File: rtl/add_test_sequencer_if.sv
// Control/RAM-side bundle of the run sequencer; the sequencer is the slave,
// the control unit plus RAM/harness side is the master.
interface add_test_sequencer_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 32
);
  logic                  pll_lock;
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [CNT_WIDTH-1:0]  cycle_count;

  modport slave (
    input  pll_lock, start, abort, last_addr,
    output r_en, r_addr, we, w_addr, busy, done, error, cycle_count
  );

  modport master (
    output pll_lock, start, abort, last_addr,
    input  r_en, r_addr, we, w_addr, busy, done, error, cycle_count
  );
endinterface

// File: rtl/valid_addr_pipe.sv
// {valid, addr} delay line of DEPTH stages with synchronous flush; aligns the
// result-RAM write strobe with the operand read it belongs to.
module valid_addr_pipe #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  src_valid,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  dly_valid,
  output logic [ADDR_WIDTH-1:0] dly_addr
);

  logic [DEPTH-1:0]                 vld_pipe;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_pipe;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= src_valid;
      addr_pipe[0] <= src_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign dly_valid = vld_pipe[DEPTH-1];
  assign dly_addr  = addr_pipe[DEPTH-1];

endmodule

// File: rtl/add_test_sequencer.sv
// Run sequencer: waits for a stable PLL lock, streams operand read addresses
// 0..last_addr, and issues the matching result writes LATENCY cycles later.
module add_test_sequencer
  import add_test_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int LATENCY     = LATENCY_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                 pll_clock,
  input  logic                 reset,
  add_test_sequencer_if.slave  bus
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int DW = $clog2(LATENCY + 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] last_q, r_addr_q;
  logic [LW-1:0]         lock_cnt, lock_inc;
  logic [DW-1:0]         drain_cnt;
  logic [CNT_WIDTH-1:0]  cyc_cnt;
  logic                  idle_like, streaming, start_acc, flush;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign streaming = (state == S_RUN) || (state == S_DRAIN);
  assign start_acc = idle_like && bus.start;
  assign lock_inc  = lock_cnt + 1'b1;
  // Anything that cancels a run in flight must also kill the writes still in the pipe.
  assign flush     = (!idle_like && bus.abort) || (streaming && !bus.pll_lock);

  always_ff @(posedge pll_clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (bus.start) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (bus.abort)                                         state_nxt = S_IDLE;
        else if (bus.pll_lock && lock_inc == LW'(LOCK_CYCLES)) state_nxt = S_RUN;
      S_RUN:
        if (bus.abort)                state_nxt = S_IDLE;
        else if (!bus.pll_lock)       state_nxt = S_ERROR;
        else if (r_addr_q == last_q)  state_nxt = S_DRAIN;
      S_DRAIN:
        if (bus.abort)                         state_nxt = S_IDLE;
        else if (!bus.pll_lock)                state_nxt = S_ERROR;
        else if (drain_cnt == DW'(LATENCY-1))  state_nxt = S_DONE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pll_clock) begin
    if (reset) begin
      last_q    <= '0;
      r_addr_q  <= '0;
      lock_cnt  <= '0;
      drain_cnt <= '0;
      cyc_cnt   <= '0;
    end else if (start_acc) begin
      last_q    <= bus.last_addr;
      r_addr_q  <= '0;
      lock_cnt  <= '0;
      drain_cnt <= '0;
      cyc_cnt   <= '0;
    end else begin
      if (state == S_WAIT_LOCK)
        lock_cnt <= bus.pll_lock ? lock_inc : '0;
      // Advancing only while staying in RUN keeps r_addr parked on last_addr, so no wrap.
      if (state == S_RUN && state_nxt == S_RUN)
        r_addr_q <= r_addr_q + 1'b1;
      if (state == S_DRAIN)
        drain_cnt <= drain_cnt + 1'b1;
      if (streaming && !bus.abort && cyc_cnt != '1)
        cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  valid_addr_pipe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (LATENCY)
  ) u_pipe (
    .clk       (pll_clock),
    .rst       (reset),
    .flush     (flush),
    .src_valid (bus.r_en),
    .src_addr  (r_addr_q),
    .dly_valid (bus.we),
    .dly_addr  (bus.w_addr)
  );

  assign bus.r_en        = (state == S_RUN);
  assign bus.r_addr      = r_addr_q;
  assign bus.busy        = (state == S_WAIT_LOCK) || streaming;
  assign bus.done        = (state == S_DONE);
  assign bus.error       = (state == S_ERROR);
  assign bus.cycle_count = cyc_cnt;

endmodule

// File: tb/tb_add_test_sequencer.sv
// Randomized scoreboard bench for add_test_sequencer: expected read/write
// events are derived from start time, lock history and cut points.
module tb_add_test_sequencer;
  import add_test_pkg::*;

  localparam int AW   = 11;
  localparam int LAT  = 6;
  localparam int LOCK = 16;
  localparam int CW   = 32;
  localparam int NONE = 32'h3fff_ffff;

  typedef struct { int cyc; int addr; } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_r[$];
  ev_t  exp_w[$];
  ev_t  er, ew;

  add_test_sequencer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  add_test_sequencer #(
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT),
    .LOCK_CYCLES(LOCK),
    .CNT_WIDTH  (CW)
  ) dut (
    .pll_clock (clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every read/write strobe must match the head of its queue.
  always @(negedge clk) begin
    if (bus.r_en === 1'b1) begin
      if (exp_r.size() == 0) chk("r_en_unexpected", 1, 0);
      else begin
        er = exp_r.pop_front();
        chk("r_cycle", cyc, er.cyc);
        chk("r_addr", bus.r_addr, er.addr);
      end
    end
    if (bus.we === 1'b1) begin
      if (exp_w.size() == 0) chk("we_unexpected", 1, 0);
      else begin
        ew = exp_w.pop_front();
        chk("w_cycle", cyc, ew.cyc);
        chk("w_addr", bus.w_addr, ew.addr);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  // Reads at r0+k, writes LAT later; anything after the cut cycle never appears.
  task automatic push_run(input int r0, input int last, input int cut);
    for (int k = 0; k <= last; k++) begin
      if (r0 + k <= cut)       exp_r.push_back('{r0 + k, k});
      if (r0 + k + LAT <= cut) exp_w.push_back('{r0 + k + LAT, k});
    end
  endtask

  task automatic issue_start(input int last, output int s);
    s = cyc;
    bus.last_addr = AW'(last);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("error_after_start", bus.error, 0);
    chk("done_after_start", bus.done, 0);
  endtask

  task automatic finish_run(input int r0, input int last);
    int d;
    d = r0 + last + 1 + LAT;
    wait_until(d - 1);
    chk("done_early", bus.done, 0);
    chk("busy_last_drain", bus.busy, 1);
    step(1);
    chk("done", bus.done, 1);
    chk("busy_in_done", bus.busy, 0);
    chk("cycle_count", bus.cycle_count, last + 1 + LAT);
  endtask

  task automatic drained();
    step(LAT + 2);
    chk("reads_missing", exp_r.size(), 0);
    chk("writes_missing", exp_w.size(), 0);
    exp_r.delete();
    exp_w.delete();
  endtask

  task automatic nominal(input int last);
    int s, r0;
    issue_start(last, s);
    r0 = s + 1 + LOCK;
    push_run(r0, last, NONE);
    finish_run(r0, last);
    drained();
  endtask

  task automatic lock_bounce(input int b, input int len);
    int s, r0, last;
    last = $urandom_range(1, 20);
    issue_start(last, s);
    wait_until(s + b);
    bus.pll_lock = 1'b0;
    step(len);
    bus.pll_lock = 1'b1;
    r0 = (s + b + len - 1) + 1 + LOCK;
    push_run(r0, last, NONE);
    wait_until(r0 - 1);
    chk("r_en_before_lock", bus.r_en, 0);
    finish_run(r0, last);
    drained();
  endtask

  task automatic lock_loss(input int last, input int k);
    int s, r0, l;
    issue_start(last, s);
    r0 = s + 1 + LOCK;
    l = r0 + k;
    push_run(r0, last, l);
    wait_until(l);
    bus.pll_lock = 1'b0;
    step(1);
    bus.pll_lock = 1'b1;
    chk("error_on_loss", bus.error, 1);
    chk("busy_on_loss", bus.busy, 0);
    chk("r_en_on_loss", bus.r_en, 0);
    chk("done_on_loss", bus.done, 0);
    drained();
    nominal(last);
  endtask

  task automatic abort_drain(input int last, input int j);
    int s, r0, a;
    issue_start(last, s);
    r0 = s + 1 + LOCK;
    a = r0 + last + j;
    push_run(r0, last, a);
    wait_until(r0 + 2);
    bus.last_addr = AW'(5);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_until(a);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    chk("busy_after_abort", bus.busy, 0);
    chk("done_after_abort", bus.done, 0);
    chk("error_after_abort", bus.error, 0);
    chk("count_at_abort", bus.cycle_count, a - r0);
    step(8);
    chk("count_frozen", bus.cycle_count, a - r0);
    chk("done_stays_low", bus.done, 0);
    drained();
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_r_en"}, bus.r_en, 0);
    chk({tag, "_r_addr"}, bus.r_addr, 0);
    chk({tag, "_we"}, bus.we, 0);
    chk({tag, "_w_addr"}, bus.w_addr, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_cycle_count"}, bus.cycle_count, 0);
  endtask

  initial begin
    int s, r0, x, last;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pll_lock = 1'b1;
    bus.last_addr = '0;
    step(3);
    zero_outputs("reset");
    reset = 1'b0;
    step(2);

    nominal(9);
    for (int i = 0; i < 3; i++) nominal($urandom_range(1, 40));

    lock_bounce(10, 1);
    for (int i = 0; i < 3; i++) lock_bounce($urandom_range(2, 14), $urandom_range(1, 3));

    lock_loss(12, 4);
    for (int i = 0; i < 3; i++) begin
      last = $urandom_range(8, 30);
      lock_loss(last, $urandom_range(1, last + LAT));
    end

    for (int i = 0; i < 3; i++) abort_drain($urandom_range(3, 25), $urandom_range(1, LAT));

    nominal(0);
    nominal(2047);

    last = 20;
    issue_start(last, s);
    r0 = s + 1 + LOCK;
    x = r0 + $urandom_range(1, 15);
    push_run(r0, last, x);
    wait_until(x);
    reset = 1'b1;
    step(1);
    zero_outputs("midrun_reset");
    reset = 1'b0;
    drained();
    nominal(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
